// File: rtl/lcd_cmd_sched.sv
// Opcode FIFO and issue scheduler in front of the 8x8 LCD engine.
// Define SCHED_STATS_EN to add the issue_cnt/err_cnt statistics ports.
module lcd_cmd_sched #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    host_cmd,
    input  logic          host_valid,
    output logic          host_ready,
    output logic          host_err,
    output logic [3:0]    eng_cmd,
    output logic          eng_cmd_valid,
    input  logic          eng_busy,
    input  logic          eng_done,
    output logic [AW:0]   fifo_level,
    output logic          sched_idle,
    output logic          finished
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]   issue_cnt,
    output logic [7:0]    err_cnt
`endif
);

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        ACK,
        EXEC,
        FINISH
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [3:0]    mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          valid_q, valid_d;
    logic [1:0]    tmr_q, tmr_d;
    logic          retry_q, retry_d;

    logic          push;
    logic          wr;
    logic          pop;

`ifdef SCHED_STATS_EN
    logic [15:0]   issue_q, issue_d;
    logic [7:0]    errc_q, errc_d;
`endif

    assign push = host_valid && ready_q;
    assign wr   = push && (host_cmd < 4'd12);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        cmd_d   = cmd_q;
        valid_d = 1'b0;
        tmr_d   = tmr_q;
        retry_d = retry_q;
        pop     = 1'b0;
        err_d   = push && !wr;

        unique case (state_q)
            BOOT: begin
                if (!eng_busy)
                    state_d = IDLE;
            end
            IDLE: begin
                if (count_q != '0 && !eng_busy) begin
                    cmd_d   = mem[head_q];
                    valid_d = 1'b1;
                    pop     = 1'b1;
                    tmr_d   = 2'd0;
                    retry_d = 1'b0;
                    state_d = ACK;
                end
            end
            ACK: begin
                // One re-strobe after four silent cycles, then give up.
                if (eng_busy) begin
                    state_d = EXEC;
                end else if (tmr_q == 2'd3) begin
                    if (!retry_q) begin
                        valid_d = 1'b1;
                        retry_d = 1'b1;
                        tmr_d   = 2'd0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + 2'd1;
                end
            end
            EXEC: begin
                if (!eng_busy) begin
                    if (cmd_q != 4'd0)
                        state_d = IDLE;
                    else if (eng_done)
                        state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = FINISH;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (wr)
            tail_d = tail_q + 1'b1;
        if (pop)
            head_d = head_q + 1'b1;
        if (wr && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !wr)
            count_d = count_q - 1'b1;

        // Anything queued behind the Write is dropped.
        if (state_d == FINISH) begin
            count_d = '0;
            head_d  = tail_d;
        end

        ready_d = (count_d != DEPTH_C) && (state_d != FINISH);
    end

`ifdef SCHED_STATS_EN
    always_comb begin
        issue_d = issue_q;
        errc_d  = errc_q;
        if (state_q == ACK && eng_busy && issue_q != 16'hFFFF)
            issue_d = issue_q + 16'd1;
        if (err_d && errc_q != 8'hFF)
            errc_d = errc_q + 8'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (wr)
            mem[tail_q] <= host_cmd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            cmd_q   <= 4'd0;
            valid_q <= 1'b0;
            tmr_q   <= 2'd0;
            retry_q <= 1'b0;
`ifdef SCHED_STATS_EN
            issue_q <= 16'd0;
            errc_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            cmd_q   <= cmd_d;
            valid_q <= valid_d;
            tmr_q   <= tmr_d;
            retry_q <= retry_d;
`ifdef SCHED_STATS_EN
            issue_q <= issue_d;
            errc_q  <= errc_d;
`endif
        end
    end

    assign host_ready    = ready_q;
    assign host_err      = err_q;
    assign eng_cmd       = cmd_q;
    assign eng_cmd_valid = valid_q;
    assign fifo_level    = count_q;
    assign sched_idle    = (state_q == IDLE) && (count_q == '0);
    assign finished      = (state_q == FINISH);

`ifdef SCHED_STATS_EN
    assign issue_cnt = issue_q;
    assign err_cnt   = errc_q;
`endif

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed bench for lcd_cmd_sched with a small engine model.
// Checks are immediate assertions at each sample point.
module tb_lcd_cmd_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] host_cmd = 4'd0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic       host_err;
    logic [3:0] eng_cmd;
    logic       eng_cmd_valid;
    logic       eng_busy;
    logic       eng_done = 1'b0;
    logic [3:0] fifo_level;
    logic       sched_idle;
    logic       finished;
`ifdef SCHED_STATS_EN
    logic [15:0] issue_cnt;
    logic [7:0]  err_cnt;
`endif

    logic boot_busy = 1'b1;
    logic ignore = 1'b0;
    int   busy_len = 2;
    int   mcnt;
    int   cyc = 0;
    int   unstable = 0;
    int   viol = 0;
    logic       prev_busy = 1'b0;
    logic [3:0] prev_cmd = 4'd0;
    logic [3:0] strobes [$];
    int         strobe_t [$];

    int errors = 0;
    int checks = 0;

    lcd_cmd_sched #(.DEPTH(8), .AW(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .host_cmd      (host_cmd),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .host_err      (host_err),
        .eng_cmd       (eng_cmd),
        .eng_cmd_valid (eng_cmd_valid),
        .eng_busy      (eng_busy),
        .eng_done      (eng_done),
        .fifo_level    (fifo_level),
        .sched_idle    (sched_idle),
        .finished      (finished)
`ifdef SCHED_STATS_EN
        ,
        .issue_cnt     (issue_cnt),
        .err_cnt       (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign eng_busy = boot_busy || (mcnt != 0);

    // Engine: busy for busy_len cycles starting the cycle after a strobe.
    always @(posedge clk or posedge reset) begin
        if (reset)
            mcnt <= 0;
        else if (mcnt != 0)
            mcnt <= mcnt - 1;
        else if (eng_cmd_valid && !ignore)
            mcnt <= busy_len;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            if (eng_cmd_valid) begin
                strobes.push_back(eng_cmd);
                strobe_t.push_back(cyc);
            end
            if (eng_cmd_valid && eng_busy)
                viol <= viol + 1;
            if (eng_busy && prev_busy && eng_cmd != prev_cmd)
                unstable <= unstable + 1;
        end
        prev_busy <= eng_busy && !reset;
        prev_cmd  <= eng_cmd;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] c);
        host_valid = 1'b1;
        host_cmd   = c;
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, host_ready, 0);
        chk({tag, "_err"}, host_err, 0);
        chk({tag, "_cmd"}, eng_cmd, 0);
        chk({tag, "_valid"}, eng_cmd_valid, 0);
        chk({tag, "_level"}, fifo_level, 0);
        chk({tag, "_idle"}, sched_idle, 0);
        chk({tag, "_fin"}, finished, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] exp_b2b [4];
        exp_b2b[0] = 4'd1;
        exp_b2b[1] = 4'd4;
        exp_b2b[2] = 4'd8;
        exp_b2b[3] = 4'd11;

        // Reset values
        @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        // Boot: engine loading for 64 cycles, opcode 5 pushed at cycle 10
        repeat (9) @(negedge clk);
        push(4'd5);
        chk("boot_level", fifo_level, 1);
        chk("boot_not_idle", sched_idle, 0);
        repeat (54) @(negedge clk);
        chk("boot_no_strobe", strobes.size(), 0);
        boot_busy = 1'b0;
        @(negedge clk);
        chk("boot_valid_lo", eng_cmd_valid, 0);
        @(negedge clk);
        chk("boot_valid_hi", eng_cmd_valid, 1);
        chk("boot_cmd", eng_cmd, 5);
        chk("boot_pop", fifo_level, 0);
        @(negedge clk);
        chk("boot_one_cycle", eng_cmd_valid, 0);
        n = 0;
        while (!sched_idle && n < 50) begin @(negedge clk); n++; end
        chk("boot_back_idle", sched_idle, 1);

        // Back-to-back issue with a 2-cycle engine
        boot_busy = 1'b1;
        push(4'd1);
        push(4'd4);
        push(4'd8);
        push(4'd11);
        chk("b2b_level4", fifo_level, 4);
        strobes.delete();
        boot_busy = 1'b0;
        n = 0;
        while (!eng_cmd_valid && n < 20) begin @(negedge clk); n++; end
        chk("b2b_first_cmd", eng_cmd, 1);
        chk("b2b_level3", fifo_level, 3);
        n = 0;
        while (!sched_idle && n < 100) begin @(negedge clk); n++; end
        chk("b2b_idle", sched_idle, 1);
        chk("b2b_nstrobe", strobes.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("b2b_order%0d", i), strobes[i], exp_b2b[i]);
        chk("b2b_level0", fifo_level, 0);

        // Full FIFO and illegal-opcode filter
        boot_busy = 1'b1;
        for (int i = 1; i <= 9; i++)
            push(4'(i));
        chk("full_level", fifo_level, 8);
        chk("full_ready", host_ready, 0);
        push(4'd13);
        chk("full_ill_noerr", host_err, 0);
        chk("full_ill_level", fifo_level, 8);
        strobes.delete();
        boot_busy = 1'b0;
        n = 0;
        while (!sched_idle && n < 200) begin @(negedge clk); n++; end
        chk("full_drain_idle", sched_idle, 1);
        chk("full_nstrobe", strobes.size(), 8);
        chk("full_first", strobes[0], 1);
        chk("full_last", strobes[7], 8);
        chk("full_ready_again", host_ready, 1);
        push(4'd13);
        chk("ill_err_pulse", host_err, 1);
        chk("ill_level", fifo_level, 0);
        @(negedge clk);
        chk("ill_err_drop", host_err, 0);

        // Write opcode ends the run
        boot_busy = 1'b1;
        push(4'd7);
        push(4'd0);
        push(4'd2);
        strobes.delete();
        boot_busy = 1'b0;
        n = 0;
        while (strobes.size() < 2 && n < 50) begin @(negedge clk); n++; end
        chk("wr_two_issued", strobes.size(), 2);
        repeat (5) @(negedge clk);
        chk("wr_wait_fin", finished, 0);
        chk("wr_wait_level", fifo_level, 1);
        chk("wr_wait_cmd", eng_cmd, 0);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        chk("wr_finished", finished, 1);
        chk("wr_flush", fifo_level, 0);
        chk("wr_ready", host_ready, 0);
        push(4'd3);
        repeat (10) @(negedge clk);
        chk("wr_sticky", finished, 1);
        chk("wr_no_push", fifo_level, 0);
        chk("wr_nstrobe", strobes.size(), 2);
        chk("wr_s0", strobes[0], 7);
        chk("wr_s1", strobes[1], 0);
        chk("hold_stable", unstable, 0);
        chk("no_valid_busy", viol, 0);

        // ACK timeout: engine ignores strobes
        boot_busy = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        boot_busy = 1'b0;
        @(negedge clk);
        ignore = 1'b1;
        strobes.delete();
        strobe_t.delete();
        push(4'd3);
        n = 0;
        while (!host_err && n < 30) begin @(negedge clk); n++; end
        chk("to_err", host_err, 1);
        chk("to_idle", sched_idle, 1);
        chk("to_nstrobe", strobes.size(), 2);
        chk("to_gap", strobe_t[1] - strobe_t[0], 4);
        chk("to_recmd", strobes[1], 3);
        chk("to_err_gap", cyc - strobe_t[1], 4);
        @(negedge clk);
        chk("to_err_drop", host_err, 0);

        // Reset in the middle of EXEC
        ignore = 1'b0;
        busy_len = 10;
        push(4'd6);
        n = 0;
        while (!eng_cmd_valid && n < 20) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        chk("mid_cmd", eng_cmd, 6);
        chk("mid_not_idle", sched_idle, 0);
        reset = 1'b1;
        boot_busy = 1'b1;
        #1;
        chk_reset_vals("mid");
        @(negedge clk);
        reset = 1'b0;
        strobes.delete();
        busy_len = 2;
        repeat (5) @(negedge clk);
        push(4'd5);
        chk("mid_boot_level", fifo_level, 1);
        repeat (3) @(negedge clk);
        chk("mid_boot_hold", strobes.size(), 0);
        boot_busy = 1'b0;
        n = 0;
        while (!eng_cmd_valid && n < 20) begin @(negedge clk); n++; end
        chk("mid_reissue", eng_cmd, 5);
        n = 0;
        while (!sched_idle && n < 50) begin @(negedge clk); n++; end
        chk("mid_final_idle", sched_idle, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
